// File: rtl/pattern_gen.sv
// Pattern generator: replays a stored 1-bit sample pattern onto a pin.
// 8192x1 pattern memory, power-of-two hold per sample, one-shot or loop.
module pattern_gen #(
  parameter int ADDR_W = 13,
  parameter int RATE_W = 4,
  parameter int HOLD_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic [ADDR_W-1:0] length,
  input  logic [RATE_W-1:0] rate,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic              out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PLAY
  } state_t;

  state_t state, state_nx;

  logic mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] len_s;
  logic [RATE_W-1:0] rate_s;
  logic              loop_s;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] fetch_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_max;
  logic              pf_bit;

  logic go;
  logic abort;
  logic prime_step;
  logic advance;
  logic finish;
  logic count;
  logic hold_end;
  logic last;

  function automatic logic [ADDR_W-1:0] wrap_inc(
    input logic [ADDR_W-1:0] p,
    input logic [ADDR_W-1:0] l
  );
    return (p == l) ? '0 : p + ADDR_W'(1);
  endfunction

  always_comb begin
    hold_max   = ~({HOLD_W{1'b1}} << rate_s);
    hold_end   = (hold == hold_max);
    last       = (ptr == len_s);
    rd_addr    = (state == IDLE) ? '0 : fetch_ptr;
    state_nx   = state;
    go         = 1'b0;
    abort      = 1'b0;
    prime_step = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    count      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = PRIME;
          go       = 1'b1;
        end
      end
      PRIME: begin
        if (stop) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end else begin
          state_nx   = PLAY;
          prime_step = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_nx = IDLE;
          abort    = 1'b1;
        end else if (!hold_end) begin
          count = 1'b1;
        end else if (last && !loop_s) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Single read port: the prefetch register always holds the next sample.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (go || prime_step || advance) begin
      pf_bit <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ptr       <= '0;
      fetch_ptr <= '0;
      hold      <= '0;
      len_s     <= '0;
      rate_s    <= '0;
      loop_s    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= finish;
      if (go) begin
        len_s     <= length;
        rate_s    <= rate;
        loop_s    <= loop;
        busy      <= 1'b1;
        ptr       <= '0;
        hold      <= '0;
        fetch_ptr <= (length == '0) ? '0 : ADDR_W'(1);
      end
      if (abort || finish) begin
        busy <= 1'b0;
        out  <= 1'b0;
      end
      if (prime_step) begin
        out       <= pf_bit;
        ptr       <= '0;
        hold      <= '0;
        fetch_ptr <= wrap_inc(fetch_ptr, len_s);
      end
      if (advance) begin
        out       <= pf_bit;
        ptr       <= wrap_inc(ptr, len_s);
        hold      <= '0;
        fetch_ptr <= wrap_inc(fetch_ptr, len_s);
      end
      if (count) begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: expected per-cycle out/busy/done
// are queued as stimulus is driven and popped on each falling edge.
module tb_pattern_gen;

  localparam int ADDR_W = 13;
  localparam int RATE_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic [ADDR_W-1:0] length;
  logic [RATE_W-1:0] rate;
  logic              loop;
  logic              start;
  logic              stop;
  logic              out;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic o;
    logic b;
    logic d;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic model [0:(2**ADDR_W)-1];
  int   n_cmp = 0;
  int   n_err = 0;

  pattern_gen #(.ADDR_W(ADDR_W), .RATE_W(RATE_W), .HOLD_W(15)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .length(length), .rate(rate), .loop(loop),
    .start(start), .stop(stop), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic write_mem(input int a, input logic d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    model[a] = d;
  endtask

  // One-shot run expectation: prime cycle, held samples, done, idle.
  task automatic push_run(input int len, input int rt);
    q.push_back('{1'b0, 1'b1, 1'b0});
    for (int i = 0; i <= len; i++)
      for (int h = 0; h < (1 << rt); h++)
        q.push_back('{model[i], 1'b1, 1'b0});
    q.push_back('{1'b0, 1'b0, 1'b1});
    q.push_back('{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    q.push_back('{1'b0, 1'b0, 1'b0});
    q.push_back('{1'b0, 1'b0, 1'b0});
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL reset got=%b want=%b", {out, busy, done}, e);
      end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_oneshot(input string nm, input int rt);
    length = 3;
    rate   = RATE_W'(rt);
    loop   = 1'b0;
    start  = 1'b1;
    push_run(3, rt);
    for (int c = 0; q.size() > 0; c++) begin
      if (c == 1) begin
        start  = 1'b0;
        length = 0;
        rate   = 4'd5;
        loop   = 1'b1;
      end
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL %s c=%0d got=%b want=%b",
                 nm, c, {out, busy, done}, e);
      end
    end
  endtask

  task automatic test_loop_stop();
    write_mem(0, 1'b1);
    write_mem(1, 1'b0);
    length = 1;
    rate   = 0;
    loop   = 1'b1;
    start  = 1'b1;
    q.push_back('{1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 11; i++)
      q.push_back('{(i % 2 == 0), 1'b1, 1'b0});
    q.push_back('{1'b0, 1'b0, 1'b0});
    q.push_back('{1'b0, 1'b0, 1'b0});
    for (int c = 0; q.size() > 0; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 12) stop = 1'b1;
      if (c == 13) stop = 1'b0;
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL loop_stop c=%0d got=%b want=%b",
                 c, {out, busy, done}, e);
      end
    end
  endtask

  task automatic test_busy_ignore();
    write_mem(0, 1'b1);
    write_mem(1, 1'b0);
    write_mem(2, 1'b1);
    write_mem(3, 1'b1);
    length = 3;
    rate   = 0;
    loop   = 1'b0;
    start  = 1'b1;
    push_run(3, 0);
    for (int c = 0; q.size() > 0; c++) begin
      start = (c == 0 || c == 2 || c == 3);
      if (c == 2) begin
        wr_en   = 1'b1;
        wr_addr = 2;
        wr_data = 1'b0;
      end
      if (c == 4) wr_en = 1'b0;
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL busy_ignore c=%0d got=%b want=%b",
                 c, {out, busy, done}, e);
      end
    end
    start = 1'b1;
    push_run(3, 0);
    for (int c = 0; q.size() > 0; c++) begin
      if (c == 1) start = 1'b0;
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL readback c=%0d got=%b want=%b",
                 c, {out, busy, done}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    length = 3;
    rate   = 3;
    loop   = 1'b0;
    start  = 1'b1;
    push_run(3, 3);
    for (int c = 0; c < 12; c++) begin
      if (c == 1) start = 1'b0;
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL reset_mid c=%0d got=%b want=%b",
                 c, {out, busy, done}, e);
      end
    end
    q.delete();
    q.push_back('{1'b0, 1'b0, 1'b0});
    q.push_back('{1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    for (int c = 0; q.size() > 0; c++) begin
      if (c == 1) reset = 1'b1;
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL reset_edge c=%0d got=%b want=%b",
                 c, {out, busy, done}, e);
      end
    end
    start = 1'b1;
    push_run(3, 3);
    for (int c = 0; q.size() > 0; c++) begin
      if (c == 1) start = 1'b0;
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL replay c=%0d got=%b want=%b",
                 c, {out, busy, done}, e);
      end
    end
  endtask

  task automatic test_len0();
    write_mem(0, 1'b1);
    length = 0;
    rate   = 1;
    loop   = 1'b0;
    start  = 1'b1;
    push_run(0, 1);
    for (int c = 0; q.size() > 0; c++) begin
      if (c == 1) start = 1'b0;
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL len0 c=%0d got=%b want=%b",
                 c, {out, busy, done}, e);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    q.push_back('{1'b0, 1'b0, 1'b0});
    q.push_back('{1'b0, 1'b0, 1'b0});
    for (int c = 0; q.size() > 0; c++) begin
      if (c == 1) begin
        start = 1'b0;
        stop  = 1'b0;
      end
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({out, busy, done} !== e) begin
        n_err++;
        $display("FAIL start_stop_idle c=%0d got=%b want=%b",
                 c, {out, busy, done}, e);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 1'b0;
    length  = '0;
    rate    = '0;
    loop    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    @(negedge clk);
    test_reset();
    write_mem(0, 1'b1);
    write_mem(1, 1'b0);
    write_mem(2, 1'b1);
    write_mem(3, 1'b1);
    test_oneshot("oneshot_r0", 0);
    test_oneshot("oneshot_r2", 2);
    test_loop_stop();
    test_busy_ignore();
    test_reset_mid();
    test_len0();
    test_start_stop_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
